// File: rtl/amount_manager_if.sv
// Keypad/start inputs and amount/countdown outputs of the charger payment core.
interface amount_manager_if;
   logic       start;
   logic [3:0] key_value;
   logic [4:0] all_money;
   logic [5:0] remaining_time;
   logic       timing;

   modport master (output start, key_value, input all_money, remaining_time, timing);
   modport slave  (input start, key_value, output all_money, remaining_time, timing);
endinterface

// File: rtl/amount_manager.sv
// Charger payment/timer core: two-digit amount entry with saturation, then a per-tick countdown.
// Define FAST_TICK_EN to shorten the tick period to 50 cycles for simulation.
module amount_manager #(
   parameter int TICK_CYCLES   = 50000000,
   parameter int MAX_MONEY     = 20,
   parameter int TIME_PER_UNIT = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   amount_manager_if.slave   bus
);

`ifdef FAST_TICK_EN
   localparam int TICK_P = 50;
`else
   localparam int TICK_P = TICK_CYCLES;
`endif

   typedef enum logic [1:0] {IDLE, ONE, FULL, CHARGING} state_t;

   state_t      state, state_nx;
   logic [3:0]  last_key;
   logic [31:0] tick_cnt;
   logic        key_evt;
   logic [3:0]  digit;
   logic [7:0]  acc;
   logic [4:0]  money_nx;
   logic [5:0]  time_nx;

   always_comb begin
      key_evt  = (bus.key_value != last_key) && (bus.key_value >= 4'd1) && (bus.key_value <= 4'd11);
      digit    = (bus.key_value == 4'd10) ? 4'd0 : bus.key_value;
      // 8-bit intermediate keeps 10*money+d exact before clamping
      acc      = (state == IDLE) ? {4'd0, digit} : 8'(bus.all_money) * 8'd10 + {4'd0, digit};
      money_nx = bus.all_money;
      state_nx = state;
      if (key_evt && state != CHARGING) begin
         if (bus.key_value == 4'd11) begin
            money_nx = '0;
            state_nx = IDLE;
         end else if (state == IDLE || state == ONE) begin
            money_nx = (acc > 8'(MAX_MONEY)) ? 5'(MAX_MONEY) : acc[4:0];
            state_nx = (state == IDLE) ? ONE : FULL;
         end
      end
      time_nx = 6'(int'(money_nx) * TIME_PER_UNIT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state              <= IDLE;
         last_key           <= '0;
         tick_cnt           <= '0;
         bus.all_money      <= '0;
         bus.remaining_time <= '0;
         bus.timing         <= 1'b0;
      end else begin
         last_key <= bus.key_value;
         if (state == CHARGING) begin
            if (tick_cnt == 32'(TICK_P - 1)) begin
               tick_cnt <= '0;
               // <=1 also retires a zero-time charge started together with a clear
               if (bus.remaining_time <= 6'd1) begin
                  bus.remaining_time <= '0;
                  bus.all_money      <= '0;
                  bus.timing         <= 1'b0;
                  state              <= IDLE;
               end else begin
                  bus.remaining_time <= bus.remaining_time - 6'd1;
               end
            end else begin
               tick_cnt <= tick_cnt + 32'd1;
            end
         end else begin
            tick_cnt           <= '0;
            bus.all_money      <= money_nx;
            bus.remaining_time <= time_nx;
            // start qualifies on the money held before this cycle's key
            if (bus.start && bus.all_money != 5'd0) begin
               state      <= CHARGING;
               bus.timing <= 1'b1;
            end else begin
               state <= state_nx;
            end
         end
      end
   end

endmodule

// File: tb/tb_amount_manager.sv
// Directed bench for amount_manager: entry, saturation, clear, start gating, countdown, async reset.
module tb_amount_manager;
   logic clk = 1'b0;
   logic rst_n;
   int   n_chk = 0;
   int   n_pass = 0;

   always #5 clk = ~clk;

   amount_manager_if bus();

   amount_manager #(.TICK_CYCLES(50)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
   endtask

   task automatic key_hold(input logic [3:0] k, input int n);
      bus.key_value = k;
      repeat (n) @(negedge clk);
   endtask

   task automatic chk_out(input string tag, input int money, input int tm, input int tmg);
      chk({tag, ".money"}, int'(bus.all_money), money);
      chk({tag, ".time"},  int'(bus.remaining_time), tm);
      chk({tag, ".timing"}, int'(bus.timing), tmg);
   endtask

   initial begin
      rst_n = 1'b0;
      bus.start = 1'b0;
      bus.key_value = 4'd0;
      repeat (3) @(negedge clk);
      chk_out("reset", 0, 0, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // held key is one event; second digit saturates; FULL ignores more
      key_hold(4'd8, 10);  chk_out("key8", 8, 16, 0);
      key_hold(4'd9, 3);   chk_out("key89_sat", 20, 40, 0);
      key_hold(4'd1, 3);   chk_out("full_ignore", 20, 40, 0);
      key_hold(4'd0, 2);
      key_hold(4'd11, 3);  chk_out("clear", 0, 0, 0);
      key_hold(4'd0, 2);

      key_hold(4'd3, 3);   key_hold(4'd0, 2);
      key_hold(4'd10, 3);  chk_out("key30_sat", 20, 40, 0);
      key_hold(4'd11, 3);  key_hold(4'd0, 2);

      // leading digit 0 still consumes the first slot
      key_hold(4'd10, 3);  chk_out("lead0", 0, 0, 0);
      key_hold(4'd0, 2);
      key_hold(4'd5, 3);   chk_out("lead0_5", 5, 10, 0);
      key_hold(4'd0, 2);
      key_hold(4'd7, 3);   chk_out("lead0_full", 5, 10, 0);
      key_hold(4'd11, 3);  key_hold(4'd0, 2);

      // 15 then start; keys ignored while charging
      key_hold(4'd1, 3);   key_hold(4'd0, 2);
      key_hold(4'd5, 3);   chk_out("key15", 15, 30, 0);
      key_hold(4'd0, 2);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      chk_out("start15", 15, 30, 1);
      key_hold(4'd11, 3);  chk_out("chg_clear_ign", 15, 30, 1);
      key_hold(4'd0, 2);
      key_hold(4'd4, 3);   chk_out("chg_digit_ign", 15, 30, 1);

      // asynchronous reset mid-countdown, observed between clock edges
      #3 rst_n = 1'b0;
      #1 chk_out("async_rst", 0, 0, 0);
      bus.key_value = 4'd0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      key_hold(4'd7, 3);   chk_out("post_rst_key", 7, 14, 0);
      key_hold(4'd0, 2);
      key_hold(4'd11, 3);  key_hold(4'd0, 2);

      // start with zero money is ignored
      bus.start = 1'b1;
      repeat (3) @(negedge clk);
      bus.start = 1'b0;
      chk_out("start_zero", 0, 0, 0);

      // key and start together: start sees the old (zero) money
      bus.key_value = 4'd5;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      chk_out("key_start_same", 5, 10, 0);
      repeat (2) @(negedge clk);
      chk("key_start_after", int'(bus.timing), 0);
      key_hold(4'd0, 2);
      key_hold(4'd11, 3);  key_hold(4'd0, 2);

      // full countdown from 2 yuan: 4,3,2,1,0 every 50 cycles
      key_hold(4'd2, 3);   chk_out("key2", 2, 4, 0);
      key_hold(4'd0, 2);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      chk_out("cd_start", 2, 4, 1);
      repeat (49) @(negedge clk);
      chk("cd_pre_tick", int'(bus.remaining_time), 4);
      for (int t = 3; t >= 1; t--) begin
         if (t == 3) repeat (1) @(negedge clk);
         else repeat (50) @(negedge clk);
         chk_out($sformatf("cd_%0d", t), 2, t, 1);
      end
      repeat (49) @(negedge clk);
      chk_out("cd_pre_end", 2, 1, 1);
      @(negedge clk);
      chk_out("cd_end", 0, 0, 0);
      key_hold(4'd6, 3);   chk_out("after_cd", 6, 12, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
